// File: rtl/actuator_scan_sequencer_pkg.sv
// actuator_scan_sequencer_pkg: shared command codes, H-bridge pair codes and FSM states for the actuator scan sequencer.
//   cmd_e    : per-slot command (off / forward / reverse / brake)
//   HB_*     : {hi,lo} pair codes driven onto row/col H-bridges
//   state_e  : scan FSM states
package actuator_scan_sequencer_pkg;
  typedef enum logic [1:0] {
    CMD_OFF = 2'b00,
    CMD_FWD = 2'b01,
    CMD_REV = 2'b10,
    CMD_BRK = 2'b11
  } cmd_e;
  localparam logic [1:0] HB_OFF = 2'b00;
  localparam logic [1:0] HB_HI  = 2'b10;
  localparam logic [1:0] HB_LO  = 2'b01;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/actuator_scan_sequencer_if.sv
// actuator_scan_sequencer_if: control inputs and pad-facing outputs of the actuator scan sequencer.
//   master : upstream side (SPI frame register / control) drives enable, trigger, frame and timing inputs
//   slave  : the sequencer, which drives the row/col selects, enables, H-bridge pairs and status
interface actuator_scan_sequencer_if #(
  parameter int NUM_ROWS = 5,
  parameter int NUM_COLS = 2,
  parameter int PULSE_W  = 16,
  parameter int DEAD_W   = 8
);
  logic                             enable_n;
  logic                             trigger_in_n;
  logic                             continuous;
  logic [2*NUM_ROWS*NUM_COLS-1:0]   frame_data;
  logic                             frame_load;
  logic [PULSE_W-1:0]               pulse_len;
  logic [DEAD_W-1:0]                dead_len;
  logic [NUM_ROWS-1:0]              rows;
  logic [NUM_COLS-1:0]              cols;
  logic [NUM_ROWS-1:0]              rows_enable;
  logic [NUM_COLS-1:0]              cols_enable;
  logic [2*NUM_ROWS-1:0]            rows_hbrige;
  logic [2*NUM_COLS-1:0]            cols_hbrige;
  logic                             trigger_out_n;
  logic                             busy;
  logic                             frame_done;
  logic [3:0]                       slot_index;
  logic                             stale;
  modport master (
    output enable_n, trigger_in_n, continuous, frame_data, frame_load, pulse_len, dead_len,
    input  rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige,
           trigger_out_n, busy, frame_done, slot_index, stale
  );
  modport slave (
    input  enable_n, trigger_in_n, continuous, frame_data, frame_load, pulse_len, dead_len,
    output rows, cols, rows_enable, cols_enable, rows_hbrige, cols_hbrige,
           trigger_out_n, busy, frame_done, slot_index, stale
  );
endinterface

// File: rtl/actuator_slot_decoder.sv
// actuator_slot_decoder: combinational map from (slot_index, cmd, drive_phase) to matrix drive vectors.
//   slot_index  : slot k = r*NUM_COLS + c
//   cmd         : command for that slot
//   drive_phase : 1 only in the drive part of a slot; 0 forces every output to 0
//   rows/cols, rows_enable/cols_enable : one-hot select and pad enable of the addressed row/col
//   rows_hbrige/cols_hbrige            : per-line {hi,lo} pairs
module actuator_slot_decoder
  import actuator_scan_sequencer_pkg::*;
#(
  parameter int NUM_ROWS = 5,
  parameter int NUM_COLS = 2
) (
  input  logic [3:0]            slot_index,
  input  cmd_e                  cmd,
  input  logic                  drive_phase,
  output logic [NUM_ROWS-1:0]   rows,
  output logic [NUM_COLS-1:0]   cols,
  output logic [NUM_ROWS-1:0]   rows_enable,
  output logic [NUM_COLS-1:0]   cols_enable,
  output logic [2*NUM_ROWS-1:0] rows_hbrige,
  output logic [2*NUM_COLS-1:0] cols_hbrige
);
  localparam logic [3:0] NC = 4'(NUM_COLS);
  logic       on;
  logic [3:0] row, col;
  logic [1:0] row_pair, col_pair;
  assign on       = drive_phase && (cmd != CMD_OFF);
  assign row      = slot_index / NC;
  assign col      = slot_index % NC;
  // brake shorts the coil: both ends pulled low
  assign row_pair = (cmd == CMD_FWD) ? HB_HI : HB_LO;
  assign col_pair = (cmd == CMD_REV) ? HB_HI : HB_LO;
  always_comb begin
    rows        = '0;
    rows_enable = '0;
    rows_hbrige = {NUM_ROWS{HB_OFF}};
    cols        = '0;
    cols_enable = '0;
    cols_hbrige = {NUM_COLS{HB_OFF}};
    for (int i = 0; i < NUM_ROWS; i++)
      if (on && row == 4'(i)) begin
        rows[i]             = 1'b1;
        rows_enable[i]      = 1'b1;
        rows_hbrige[2*i+:2] = row_pair;
      end
    for (int i = 0; i < NUM_COLS; i++)
      if (on && col == 4'(i)) begin
        cols[i]             = 1'b1;
        cols_enable[i]      = 1'b1;
        cols_hbrige[2*i+:2] = col_pair;
      end
  end
endmodule

// File: rtl/actuator_scan_sequencer.sv
// actuator_scan_sequencer: walks every slot of the actuator matrix, dead gap then drive pulse per slot.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : enable_n, trigger_in_n, continuous, frame_data/frame_load, pulse_len, dead_len in;
//                    rows/cols, *_enable, *_hbrige, trigger_out_n, busy, frame_done, slot_index, stale out
//   ACT_SEQ_WATCHDOG_EN : when defined, frames started without a fresh load are counted and after
//                         WDOG_FRAMES of them the active frame is cleared and stale is raised.
module actuator_scan_sequencer
  import actuator_scan_sequencer_pkg::*;
#(
  parameter int NUM_ROWS    = 5,
  parameter int NUM_COLS    = 2,
  parameter int PULSE_W     = 16,
  parameter int DEAD_W      = 8,
  parameter int WDOG_FRAMES = 4
) (
  input logic                      clock,
  input logic                      reset_n,
  actuator_scan_sequencer_if.slave bus
);
  localparam int         SLOTS = NUM_ROWS * NUM_COLS;
  localparam int         FW    = 2 * SLOTS;
  localparam int         CNT_W = (PULSE_W > DEAD_W) ? PULSE_W : DEAD_W;
  localparam logic [3:0] LAST  = 4'(SLOTS - 1);
  if (SLOTS > 16 || WDOG_FRAMES < 1) begin : g_param_check
    $error("actuator_scan_sequencer: NUM_ROWS*NUM_COLS must be <= 16 and WDOG_FRAMES >= 1");
  end
  // remaining-cycles reload value; a zero length still takes one cycle
  function automatic logic [CNT_W-1:0] span(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            slot_q, slot_d;
  logic [PULSE_W-1:0]    plen_q, plen_d;
  logic [DEAD_W-1:0]     dlen_q, dlen_d;
  logic [FW-1:0]         shadow_q, shadow_d, active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  trig_prev_q, start;
  logic                  trig_out_q, trig_out_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]            cmd_d;
  logic [NUM_ROWS-1:0]   rows_q, rows_d, rows_en_q, rows_en_d;
  logic [NUM_COLS-1:0]   cols_q, cols_d, cols_en_q, cols_en_d;
  logic [2*NUM_ROWS-1:0] rows_hb_q, rows_hb_d;
  logic [2*NUM_COLS-1:0] cols_hb_q, cols_hb_d;
`ifdef ACT_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_FRAMES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            stale_q, stale_d;
`endif
  // a trigger edge only counts while idle; busy-time edges are dropped, not queued
  assign start = !bus.enable_n &&
                 ((state_q == ST_IDLE && trig_prev_q && !bus.trigger_in_n) ||
                  (state_q == ST_DONE && bus.continuous));
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    plen_d    = plen_q;
    dlen_d    = dlen_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
`ifdef ACT_SEQ_WATCHDOG_EN
    wd_d      = wd_q;
    stale_d   = stale_q;
`endif
    case (state_q)
      ST_DEAD:
        if (cnt_q == '0) begin
          state_d = ST_DRIVE;
          cnt_d   = span(CNT_W'(plen_q));
        end else cnt_d = cnt_q - CNT_W'(1);
      ST_DRIVE:
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (slot_q == LAST) state_d = ST_DONE;
        else begin
          state_d = ST_DEAD;
          slot_d  = slot_q + 4'd1;
          cnt_d   = span(CNT_W'(dlen_q));
        end
      ST_DONE: begin
        state_d = ST_IDLE;
        slot_d  = '0;
      end
      default: ;
    endcase
    if (start) begin
      state_d = ST_DEAD;
      slot_d  = '0;
      plen_d  = bus.pulse_len;
      dlen_d  = bus.dead_len;
      cnt_d   = span(CNT_W'(bus.dead_len));
      // the frame copies the shadow as it was before any same-cycle load
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
`ifdef ACT_SEQ_WATCHDOG_EN
      else begin
        wd_d = (wd_q == WD_W'(WDOG_FRAMES)) ? wd_q : wd_q + WD_W'(1);
        if (wd_d == WD_W'(WDOG_FRAMES)) begin
          active_d = '0;
          stale_d  = 1'b1;
        end
      end
`endif
    end
    if (bus.frame_load) begin
      shadow_d  = bus.frame_data;
      pending_d = 1'b1;
`ifdef ACT_SEQ_WATCHDOG_EN
      wd_d      = '0;
      stale_d   = 1'b0;
`endif
    end
    if (bus.enable_n) begin
      state_d = ST_IDLE;
      slot_d  = '0;
    end
    trig_out_d = !start;
    busy_d     = state_d != ST_IDLE;
    done_d     = state_d == ST_DONE;
  end
  assign cmd_d = active_d[{slot_d, 1'b0} +: 2];
  // decode from next-state values so every pad output comes straight from a flop
  actuator_slot_decoder #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)) u_dec (
    .slot_index  (slot_d),
    .cmd         (cmd_e'(cmd_d)),
    .drive_phase (state_d == ST_DRIVE),
    .rows        (rows_d),
    .cols        (cols_d),
    .rows_enable (rows_en_d),
    .cols_enable (cols_en_d),
    .rows_hbrige (rows_hb_d),
    .cols_hbrige (cols_hb_d)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      plen_q      <= '0;
      dlen_q      <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      trig_prev_q <= 1'b1;
      trig_out_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      rows_en_q   <= '0;
      cols_en_q   <= '0;
      rows_hb_q   <= '0;
      cols_hb_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      plen_q      <= plen_d;
      dlen_q      <= dlen_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      trig_prev_q <= bus.trigger_in_n;
      trig_out_q  <= trig_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      rows_en_q   <= rows_en_d;
      cols_en_q   <= cols_en_d;
      rows_hb_q   <= rows_hb_d;
      cols_hb_q   <= cols_hb_d;
    end
  end
`ifdef ACT_SEQ_WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stale_q <= stale_d;
    end
  end
  assign bus.stale = stale_q;
`else
  assign bus.stale = 1'b0;
`endif
  assign bus.rows          = rows_q;
  assign bus.cols          = cols_q;
  assign bus.rows_enable   = rows_en_q;
  assign bus.cols_enable   = cols_en_q;
  assign bus.rows_hbrige   = rows_hb_q;
  assign bus.cols_hbrige   = cols_hb_q;
  assign bus.trigger_out_n = trig_out_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.slot_index    = slot_q;
endmodule

// File: tb/tb_actuator_scan_sequencer.sv
// tb_actuator_scan_sequencer: directed, table-driven bench for actuator_scan_sequencer.
module tb_actuator_scan_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  actuator_scan_sequencer_if bus ();
  actuator_scan_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic [3:0] slot;
    logic [1:0] cmd;
    logic [4:0] r;
    logic [1:0] c;
    logic [9:0] rhb;
    logic [3:0] chb;
  } vec_t;
  vec_t tv[7];
  int   n_chk = 0;
  int   n_fail = 0;
  logic ok_a, ok_b, bad;
  int   nlow;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clock);
  endtask
  function automatic logic [27:0] outv();
    return {bus.rows, bus.cols, bus.rows_enable, bus.cols_enable, bus.rows_hbrige, bus.cols_hbrige};
  endfunction
  function automatic logic [27:0] drv(input logic [4:0] r, input logic [1:0] c,
                                      input logic [9:0] rhb, input logic [3:0] chb);
    return {r, c, r, c, rhb, chb};
  endfunction
  function automatic logic pair11();
    logic b = 1'b0;
    for (int i = 0; i < 5; i++) b |= (bus.rows_hbrige[2*i+:2] == 2'b11);
    for (int i = 0; i < 2; i++) b |= (bus.cols_hbrige[2*i+:2] == 2'b11);
    return b;
  endfunction
  task automatic load(input logic [19:0] d);
    bus.frame_data = d;
    bus.frame_load = 1'b1;
    step();
    bus.frame_load = 1'b0;
  endtask
  task automatic start();
    bus.trigger_in_n = 1'b0;
    step();
    bus.trigger_in_n = 1'b1;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (bus.frame_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(name, 32'(bus.frame_done), 32'd1);
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
  initial begin
    tv[0] = '{4'd0, 2'b01, 5'b00001, 2'b01, 10'b0000000010, 4'b0001};
    tv[1] = '{4'd9, 2'b10, 5'b10000, 2'b10, 10'b0100000000, 4'b1000};
    tv[2] = '{4'd5, 2'b11, 5'b00100, 2'b10, 10'b0000010000, 4'b0100};
    tv[3] = '{4'd2, 2'b01, 5'b00010, 2'b01, 10'b0000001000, 4'b0001};
    tv[4] = '{4'd7, 2'b00, 5'b00000, 2'b00, 10'b0000000000, 4'b0000};
    tv[5] = '{4'd6, 2'b10, 5'b01000, 2'b01, 10'b0001000000, 4'b0010};
    tv[6] = '{4'd3, 2'b11, 5'b00010, 2'b10, 10'b0000000100, 4'b0100};
    bus.enable_n     = 1'b0;
    bus.trigger_in_n = 1'b1;
    bus.continuous   = 1'b0;
    bus.frame_data   = '0;
    bus.frame_load   = 1'b0;
    bus.pulse_len    = '0;
    bus.dead_len     = '0;
    repeat (3) step();
    chk("reset_outputs", 32'(outv()), 32'd0);
    chk("reset_trigger_out_n", 32'(bus.trigger_out_n), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
    chk("reset_slot_index", 32'(bus.slot_index), 32'd0);
    chk("reset_stale", 32'(bus.stale), 32'd0);
    reset_n = 1'b1;
    step();
    // table: one commanded slot per frame, dead=1 pulse=2
    bus.pulse_len = 16'd2;
    bus.dead_len  = 8'd1;
    for (int t = 0; t < 7; t++) begin
      load(20'(tv[t].cmd) << (2 * tv[t].slot));
      start();
      repeat (3 * int'(tv[t].slot)) step();
      chk($sformatf("tbl%0d_dead_out", t), 32'(outv()), 32'd0);
      chk($sformatf("tbl%0d_dead_slot", t), 32'(bus.slot_index), 32'(tv[t].slot));
      step();
      chk($sformatf("tbl%0d_drive_out", t), 32'(outv()), 32'(drv(tv[t].r, tv[t].c, tv[t].rhb, tv[t].chb)));
      chk($sformatf("tbl%0d_drive_slot", t), 32'(bus.slot_index), 32'(tv[t].slot));
      wait_done($sformatf("tbl%0d_done", t));
    end
    // single frame: slot0 fwd, slot9 rev, dead=2 pulse=4
    bus.pulse_len = 16'd4;
    bus.dead_len  = 8'd2;
    load(20'h80001);
    start();
    ok_a = 1'b1;
    ok_b = 1'b1;
    bad  = 1'b0;
    for (int i = 1; i <= 61; i++) begin
      if (i > 1) step();
      if (i == 1) begin
        chk("single_trig_low", 32'(bus.trigger_out_n), 32'd0);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_slot0", 32'(bus.slot_index), 32'd0);
      end
      if (i == 2) chk("single_trig_one_cycle", 32'(bus.trigger_out_n), 32'd1);
      if (i == 2) chk("single_dead_zero", 32'(outv()), 32'd0);
      if (i >= 3 && i <= 6) ok_a &= (outv() == drv(5'b00001, 2'b01, 10'b0000000010, 4'b0001));
      if (i == 7) chk("single_slot1_dead", 32'(outv()), 32'd0);
      if (i >= 57 && i <= 60) ok_b &= (outv() == drv(5'b10000, 2'b10, 10'b0100000000, 4'b1000));
      if (i < 61) bad |= bus.frame_done | pair11();
      if (i == 61) chk("single_done_at_60", 32'(bus.frame_done), 32'd1);
    end
    chk("single_slot0_drive4", 32'(ok_a), 32'd1);
    chk("single_slot9_drive4", 32'(ok_b), 32'd1);
    chk("single_no_early_done_or_11", 32'(bad), 32'd0);
    step();
    chk("single_idle_busy", 32'(bus.busy), 32'd0);
    // zero lengths: every slot forward, alternating dead/drive single cycles
    bus.pulse_len = 16'd0;
    bus.dead_len  = 8'd0;
    load(20'h55555);
    start();
    ok_a = 1'b1;
    ok_b = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      if (i > 1) step();
      if (i < 21 && (i % 2) == 1) ok_a &= (outv() == 28'd0);
      if (i < 21 && (i % 2) == 0) ok_b &= (outv() != 28'd0) && (bus.slot_index == 4'(i / 2 - 1));
      if (i == 21) chk("zero_done_at_20", 32'(bus.frame_done), 32'd1);
    end
    chk("zero_gap_cycles", 32'(ok_a), 32'd1);
    chk("zero_drive_cycles", 32'(ok_b), 32'd1);
    step();
    // abort in slot 3 drive
    bus.pulse_len = 16'd4;
    bus.dead_len  = 8'd2;
    load(20'h55555);
    start();
    repeat (21) step();
    chk("abort_slot3", 32'(bus.slot_index), 32'd3);
    chk("abort_driving", 32'(outv()), 32'(drv(5'b00010, 2'b10, 10'b0000001000, 4'b0100)));
    bus.enable_n = 1'b1;
    step();
    chk("abort_outputs_zero", 32'(outv()), 32'd0);
    chk("abort_busy_low", 32'(bus.busy), 32'd0);
    bus.enable_n = 1'b0;
    bad = 1'b0;
    repeat (80) begin
      step();
      bad |= bus.frame_done | bus.busy;
    end
    chk("abort_no_done_no_restart", 32'(bad), 32'd0);
    start();
    chk("abort_retrig_slot", 32'(bus.slot_index), 32'd0);
    chk("abort_retrig_trig", 32'(bus.trigger_out_n), 32'd0);
    wait_done("abort_retrig_done");
    // load B on the start cycle while A is pending
    bus.pulse_len = 16'd1;
    bus.dead_len  = 8'd1;
    load(20'h00001);
    bus.frame_data   = 20'h00002;
    bus.frame_load   = 1'b1;
    bus.trigger_in_n = 1'b0;
    step();
    bus.frame_load   = 1'b0;
    bus.trigger_in_n = 1'b1;
    step();
    chk("simul_uses_A", 32'(outv()), 32'(drv(5'b00001, 2'b01, 10'b0000000010, 4'b0001)));
    wait_done("simul_A_done");
    start();
    step();
    chk("simul_next_uses_B", 32'(outv()), 32'(drv(5'b00001, 2'b01, 10'b0000000001, 4'b0010)));
    wait_done("simul_B_done");
    // continuous: three back-to-back frames of 20 cycles, period 21
    load(20'h55555);
    bus.continuous = 1'b1;
    start();
    nlow = 0;
    ok_a = 1'b1;
    bad  = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (i > 1) step();
      if (!bus.trigger_out_n) begin
        nlow++;
        if (i != 1 && i != 22 && i != 43) ok_a = 1'b0;
      end
      if (i <= 63) bad |= !bus.busy;
      if (i == 64) chk("cont_idle_after", 32'(bus.busy), 32'd0);
      if (i == 10) bus.trigger_in_n = 1'b0;
      if (i == 11) bus.trigger_in_n = 1'b1;
      if (i == 62) bus.continuous = 1'b0;
    end
    chk("cont_trig_count", 32'(nlow), 32'd3);
    chk("cont_trig_spacing", 32'(ok_a), 32'd1);
    chk("cont_no_gap", 32'(bad), 32'd0);
`ifdef ACT_SEQ_WATCHDOG_EN
    load(20'h00001);
    ok_a = 1'b1;
    for (int f = 0; f < 5; f++) begin
      start();
      step();
      if (f < 4) ok_a &= (outv() == drv(5'b00001, 2'b01, 10'b0000000010, 4'b0001)) && !bus.stale;
      else begin
        chk("wdog_frame5_off", 32'(outv()), 32'd0);
        chk("wdog_stale_set", 32'(bus.stale), 32'd1);
      end
      wait_done($sformatf("wdog_done%0d", f));
    end
    chk("wdog_frames1to4_drive", 32'(ok_a), 32'd1);
    load(20'h00001);
    chk("wdog_stale_cleared", 32'(bus.stale), 32'd0);
`else
    chk("stale_tied_low", 32'(bus.stale), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
